// File: rtl/traffic_pkg.sv
// Shared definitions for the two-road traffic-light phase sequencer.
//   phase_e  : state codes, also driven out on the phase port
//   dir_e    : which road gets the next green after an all-red clearance
//   LAMP_*   : {R,Y,G} one-hot lamp codes
//   ns_lamp / ew_lamp : lamp head value for a given phase
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G      = 3'd0,
    NS_Y      = 3'd1,
    ALL_RED   = 3'd2,
    EW_G      = 3'd3,
    EW_Y      = 3'd4,
    PED_WALK  = 3'd5,
    EMERGENCY = 3'd6
  } phase_e;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic logic [2:0] ns_lamp(input phase_e p);
    case (p)
      NS_G:    return LAMP_G;
      NS_Y:    return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] ew_lamp(input phase_e p);
    case (p)
      EW_G:    return LAMP_G;
      EW_Y:    return LAMP_Y;
      default: return LAMP_R;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk into single-cycle phase ticks.
//   clk  : system clock
//   rst  : synchronous active-high reset, clears the divider
//   en   : 1 = divider advances, 0 = divider frozen (no ticks)
//   tick : one-cycle pulse every TICK_DIV enabled clk cycles
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/traffic_phase_controller.sv
// Two-road (NS/EW) traffic-light phase sequencer with pedestrian service
// and emergency all-red override. All outputs are registered.
//   clk, rst  : system clock, synchronous active-high reset
//   en        : 1 = phase ticks advance, 0 = prescaler and timer frozen
//   ped_req   : pedestrian button (any pulse width, latched)
//   emg       : emergency request (level)
//   ns_light  : NS head {R,Y,G} one-hot
//   ew_light  : EW head {R,Y,G} one-hot
//   ped_walk  : walk lamp, high only in PED_WALK
//   phase     : current state code (traffic_pkg::phase_e)
//   remaining : ticks left in the current phase minus 1
import traffic_pkg::*;

module traffic_phase_controller #(
  parameter int TICK_DIV = 4,
  parameter int GREEN_T  = 8,
  parameter int YELLOW_T = 3,
  parameter int ALLRED_T = 1,
  parameter int PED_T    = 5,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ped_req,
  input  logic             emg,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic             ped_walk,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] remaining
);

  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_T - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] PED_LD    = CNT_W'(PED_T - 1);

  logic tick;

  phase_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  dir_e             dir_q, dir_d;
  logic             ped_q, ped_d;
  logic [2:0]       ns_light_q, ns_light_d;
  logic [2:0]       ew_light_q, ew_light_d;
  logic             ped_walk_q, ped_walk_d;
  logic             expire;

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    expire  = tick && (rem_q == '0);
    // PED_WALK ignores the button; the walk it would request is being served.
    ped_d   = ped_q | (ped_req && (state_q != PED_WALK));
    if (tick && (rem_q != '0)) begin
      rem_d = rem_q - CNT_W'(1);
    end

    case (state_q)
      NS_G: begin
        // Emergency cuts green short immediately, but still via yellow.
        if (emg || expire) begin
          state_d = NS_Y;
          rem_d   = YELLOW_LD;
        end
      end
      EW_G: begin
        if (emg || expire) begin
          state_d = EW_Y;
          rem_d   = YELLOW_LD;
        end
      end
      NS_Y: begin
        if (expire) begin
          state_d = ALL_RED;
          rem_d   = ALLRED_LD;
          dir_d   = DIR_EW;
        end
      end
      EW_Y: begin
        if (expire) begin
          state_d = ALL_RED;
          rem_d   = ALLRED_LD;
          dir_d   = DIR_NS;
        end
      end
      ALL_RED: begin
        if (expire) begin
          if (emg) begin
            state_d = EMERGENCY;
            rem_d   = '0;
          end else if (ped_q) begin
            state_d = PED_WALK;
            rem_d   = PED_LD;
            ped_d   = 1'b0;
          end else if (dir_q == DIR_NS) begin
            state_d = NS_G;
            rem_d   = GREEN_LD;
          end else begin
            state_d = EW_G;
            rem_d   = GREEN_LD;
          end
        end
      end
      PED_WALK: begin
        if (expire) begin
          if (emg) begin
            state_d = EMERGENCY;
            rem_d   = '0;
          end else if (dir_q == DIR_NS) begin
            state_d = NS_G;
            rem_d   = GREEN_LD;
          end else begin
            state_d = EW_G;
            rem_d   = GREEN_LD;
          end
        end
      end
      EMERGENCY: begin
        // Held without ticks; release always passes through a full clearance.
        rem_d = '0;
        if (!emg) begin
          state_d = ALL_RED;
          rem_d   = ALLRED_LD;
        end
      end
      default: begin
        state_d = ALL_RED;
        rem_d   = ALLRED_LD;
      end
    endcase

    ns_light_d = ns_lamp(state_d);
    ew_light_d = ew_lamp(state_d);
    ped_walk_d = (state_d == PED_WALK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ALL_RED;
      rem_q      <= ALLRED_LD;
      dir_q      <= DIR_NS;
      ped_q      <= 1'b0;
      ns_light_q <= LAMP_R;
      ew_light_q <= LAMP_R;
      ped_walk_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      dir_q      <= dir_d;
      ped_q      <= ped_d;
      ns_light_q <= ns_light_d;
      ew_light_q <= ew_light_d;
      ped_walk_q <= ped_walk_d;
    end
  end

  assign ns_light  = ns_light_q;
  assign ew_light  = ew_light_q;
  assign ped_walk  = ped_walk_q;
  assign phase     = state_q;
  assign remaining = rem_q;

endmodule
